// File: rtl/imem_loader.sv
// imem_loader: boot loader that turns a length-prefixed little-endian byte stream
// into 32-bit instruction-memory writes, holding the CPU until the image is complete.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      reload request, honoured only in DONE
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte (HDR_LO, HDR_HI, DATA)
//   mem_we     one-cycle write pulse per assembled word
//   mem_addr   word-aligned byte address of the write
//   mem_wdata  assembled instruction word
//   cpu_hold   processor must not advance (everywhere except DONE)
//   done       image loaded (DONE state)
//   err        header length exceeds capacity (ERR state)
module imem_loader #(
  parameter int INST_MEMORY_ADDR_BUS_WIDTH = 16,
  parameter int INST_MEMORY_DATA_BUS_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [7:0]                            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  mem_we,
  output logic [INST_MEMORY_ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [INST_MEMORY_DATA_BUS_WIDTH-1:0] mem_wdata,
  output logic                                  cpu_hold,
  output logic                                  done,
  output logic                                  err
);

  localparam int AW = INST_MEMORY_ADDR_BUS_WIDTH;
  localparam int DW = INST_MEMORY_DATA_BUS_WIDTH;
  localparam int IW = AW - 2;
  localparam logic [31:0] CAP = 32'(1) << IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_cnt;
  logic [1:0]      r_bcnt;
  logic [23:0]     r_word;
  logic [IW-1:0]   r_idx;
  logic            r_last;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_st_lo;
  logic            w_st_hi;
  logic            w_st_data;
  logic            w_acc;
  logic [15:0]     w_n;
  logic [31:0]     w_n32;
  logic [31:0]     w_idx32;
  logic [31:0]     w_cnt_m1;
  logic            w_last;

  assign w_st_lo   = (r_state == S_HDR_LO);
  assign w_st_hi   = (r_state == S_HDR_HI);
  assign w_st_data = (r_state == S_DATA);

  assign in_ready  = w_st_lo | w_st_hi | w_st_data;
  assign w_acc     = in_valid & in_ready;

  // Full count as seen during the HDR_HI handshake.
  assign w_n       = {in_data, r_cnt[7:0]};
  assign w_n32     = {16'd0, w_n};

  // The word being written now is the final one of the image.
  assign w_idx32   = 32'(r_idx);
  assign w_cnt_m1  = {16'd0, r_cnt} - 32'd1;
  assign w_last    = (w_idx32 == w_cnt_m1);

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_hold  = (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_acc) w_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (w_acc) begin
          if (w_n == 16'd0)
            w_next = S_DONE;
          else if (w_n32 > CAP)
            w_next = S_ERR;
          else
            w_next = S_DATA;
        end
      end
      S_DATA: begin
        // Leave once the final word's write pulse is on the bus.
        if (r_we && r_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (start) w_next = S_HDR_LO;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      // Each new image restarts at word 0, byte 0.
      if (r_state == S_IDLE || r_state == S_DONE) begin
        r_bcnt <= '0;
        r_idx  <= '0;
        r_last <= 1'b0;
      end
      if (w_acc) begin
        unique case (1'b1)
          w_st_lo: r_cnt[7:0]  <= in_data;
          w_st_hi: r_cnt[15:8] <= in_data;
          w_st_data: begin
            r_bcnt <= r_bcnt + 2'd1;
            unique case (r_bcnt)
              2'd0: r_word[7:0]   <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[23:16] <= in_data;
              default: begin
                r_we    <= 1'b1;
                r_addr  <= {r_idx, 2'b00};
                r_wdata <= {in_data, r_word};
                r_idx   <= r_idx + 1'b1;
                r_last  <= w_last;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Expected writes are derived from the byte stream by plain arithmetic.
module tb_imem_loader;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  imem_loader #(
    .INST_MEMORY_ADDR_BUS_WIDTH(AW),
    .INST_MEMORY_DATA_BUS_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit tmo = 0;
  bit rnd_start = 0;
  int done_cyc = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  int            hs_q[$];
  logic [7:0]    strm[$];
  logic [AW-1:0] exp_a[$];
  logic [31:0]   exp_d[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    hs_q.delete(); tmo = 0;
  endtask

  // Reference model: word i = bytes 4i..4i+3 of the payload, LSB first.
  task automatic build_exp();
    int n;
    exp_a.delete(); exp_d.delete();
    n = int'(strm[0]) + 256 * int'(strm[1]);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(AW'(4 * i));
      exp_d.push_back(int'(strm[4*i+2])
        + (int'(strm[4*i+3]) << 8)
        + (int'(strm[4*i+4]) << 16)
        + (int'(strm[4*i+5]) << 24));
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    bit  acc;
    n = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    if (rnd_start) start = ($urandom_range(2, 0) == 0);
    forever begin
      @(negedge clk);
      acc = in_ready;
      if (acc) hs_q.push_back(cyc);
      @(posedge clk); #1;
      if (acc) break;
      if (++n > 50) begin tmo = 1; break; end
    end
    in_valid = 1'b0;
    start = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic send_all(input int gmin, input int gmax);
    foreach (strm[i])
      send_byte(strm[i], $urandom_range(gmax, gmin));
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        done_cyc = cyc; break;
      end
      if (++n > limit) begin tmo = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total += 7;
    if (in_ready !== 1'b0) begin bad++;
      $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    if (mem_we !== 1'b0) begin bad++;
      $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    if (mem_addr !== '0) begin bad++;
      $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    if (mem_wdata !== '0) begin bad++;
      $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
    if (cpu_hold !== 1'b1) begin bad++;
      $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
    if (done !== 1'b0) begin bad++;
      $display("FAIL rst_done got=%b exp=0", done); end
    if (err !== 1'b0) begin bad++;
      $display("FAIL rst_err got=%b exp=0", err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++;
      $display("FAIL rdy_early got=%b exp=0", in_ready); end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++;
      $display("FAIL rdy_after_rst got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_mon();
    strm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00,
             8'h93, 8'h05, 8'hb0, 8'h00};
    send_all(0, 0);
    wait_done(50);
    total += 8;
    if (tmo !== 1'b0) begin bad++;
      $display("FAIL basic_timeout got=%b exp=0", tmo); end
    if (wa_q.size() !== 2) begin bad++;
      $display("FAIL basic_nwr got=%0d exp=2", wa_q.size()); end
    else begin
      if (wa_q[0] !== 16'h0000 || wd_q[0] !== 32'h00A00513) begin
        bad++;
        $display("FAIL basic_w0 got=%h/%h exp=0000/00a00513",
                 wa_q[0], wd_q[0]);
      end
      if (wa_q[1] !== 16'h0004 || wd_q[1] !== 32'h00B00593) begin
        bad++;
        $display("FAIL basic_w1 got=%h/%h exp=0004/00b00593",
                 wa_q[1], wd_q[1]);
      end
      if (done_cyc !== wc_q[1] + 1) begin bad++;
        $display("FAIL basic_done_time got=%0d exp=%0d",
                 done_cyc, wc_q[1] + 1); end
    end
    if (done !== 1'b1) begin bad++;
      $display("FAIL basic_done got=%b exp=1", done); end
    if (cpu_hold !== 1'b0) begin bad++;
      $display("FAIL basic_hold got=%b exp=0", cpu_hold); end
    if (mem_we !== 1'b0) begin bad++;
      $display("FAIL basic_we_idle got=%b exp=0", mem_we); end
  endtask

  task automatic test_reload();
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    total += 4;
    if (cpu_hold !== 1'b0) begin bad++;
      $display("FAIL rl_hold0 got=%b exp=0", cpu_hold); end
    if (done !== 1'b1) begin bad++;
      $display("FAIL rl_done0 got=%b exp=1", done); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (cpu_hold !== 1'b1) begin bad++;
      $display("FAIL rl_hold1 got=%b exp=1", cpu_hold); end
    if (done !== 1'b0) begin bad++;
      $display("FAIL rl_done1 got=%b exp=0", done); end
    @(posedge clk); #1;
    strm = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
    send_all(0, 1);
    wait_done(50);
    total += 3;
    if (wa_q.size() !== 1) begin bad++;
      $display("FAIL rl_nwr got=%0d exp=1", wa_q.size()); end
    else if (wa_q[0] !== 16'h0 || wd_q[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rl_w0 got=%h/%h exp=0000/deadbeef",
               wa_q[0], wd_q[0]);
    end
    if (done !== 1'b1 || tmo !== 1'b0) begin bad++;
      $display("FAIL rl_done got=%b/%b exp=1/0", done, tmo); end
    if (cpu_hold !== 1'b0) begin bad++;
      $display("FAIL rl_hold_end got=%b exp=0", cpu_hold); end
  endtask

  task automatic test_bubbles();
    clear_mon();
    pulse_start();
    strm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00,
             8'h93, 8'h05, 8'hb0, 8'h00};
    build_exp();
    send_all(3, 3);
    wait_done(50);
    total += 2;
    if (tmo !== 1'b0 || done !== 1'b1) begin bad++;
      $display("FAIL bub_done got=%b/%b exp=0/1", tmo, done); end
    if (wa_q.size() !== exp_a.size()) begin bad++;
      $display("FAIL bub_nwr got=%0d exp=%0d",
               wa_q.size(), exp_a.size()); end
    else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        total++;
        if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
          bad++;
          $display("FAIL bub_w%0d got=%h/%h exp=%h/%h", i,
                   wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
        end
        total++;
        if (wc_q[i] !== hs_q[4*i+5] + 1) begin bad++;
          $display("FAIL bub_lat%0d got=%0d exp=%0d", i,
                   wc_q[i], hs_q[4*i+5] + 1); end
      end
    end
  endtask

  task automatic test_zero();
    clear_mon();
    pulse_start();
    strm = '{8'h00, 8'h00};
    send_all(0, 2);
    wait_done(20);
    total += 4;
    if (tmo !== 1'b0 || done !== 1'b1) begin bad++;
      $display("FAIL zero_done got=%b/%b exp=0/1", tmo, done); end
    if (hs_q.size() == 2 && done_cyc !== hs_q[1] + 1) begin bad++;
      $display("FAIL zero_time got=%0d exp=%0d",
               done_cyc, hs_q[1] + 1); end
    if (wa_q.size() !== 0) begin bad++;
      $display("FAIL zero_nwr got=%0d exp=0", wa_q.size()); end
    if (cpu_hold !== 1'b0) begin bad++;
      $display("FAIL zero_hold got=%b exp=0", cpu_hold); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      clear_mon();
      pulse_start();
      n = $urandom_range(6, 1);
      strm.delete();
      strm.push_back(8'(n));
      strm.push_back(8'h00);
      for (int k = 0; k < 4 * n; k++) strm.push_back(8'($urandom));
      build_exp();
      rnd_start = 1;
      send_all(0, 2);
      rnd_start = 0;
      wait_done(50);
      total += 2;
      if (tmo !== 1'b0 || done !== 1'b1) begin bad++;
        $display("FAIL rnd%0d_done got=%b/%b exp=0/1",
                 it, tmo, done); end
      if (wa_q.size() !== exp_a.size()) begin bad++;
        $display("FAIL rnd%0d_nwr got=%0d exp=%0d", it,
                 wa_q.size(), exp_a.size()); end
      else begin
        for (int i = 0; i < exp_a.size(); i++) begin
          total++;
          if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i] ||
              wc_q[i] !== hs_q[4*i+5] + 1) begin
            bad++;
            $display("FAIL rnd%0d_w%0d got=%h/%h exp=%h/%h",
                     it, i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    pulse_start();
    strm = '{8'h01, 8'h40};
    send_all(0, 1);
    wait_done(20);
    total += 5;
    if (err !== 1'b1 || tmo !== 1'b0) begin bad++;
      $display("FAIL ovf_err got=%b/%b exp=1/0", err, tmo); end
    if (hs_q.size() == 2 && done_cyc !== hs_q[1] + 1) begin bad++;
      $display("FAIL ovf_time got=%0d exp=%0d",
               done_cyc, hs_q[1] + 1); end
    if (in_ready !== 1'b0) begin bad++;
      $display("FAIL ovf_rdy got=%b exp=0", in_ready); end
    if (cpu_hold !== 1'b1) begin bad++;
      $display("FAIL ovf_hold got=%b exp=1", cpu_hold); end
    if (done !== 1'b0) begin bad++;
      $display("FAIL ovf_done got=%b exp=0", done); end
    pulse_start();
    in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(negedge clk);
    total += 3;
    if (err !== 1'b1 || done !== 1'b0) begin bad++;
      $display("FAIL ovf_start got=%b/%b exp=1/0", err, done); end
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin bad++;
      $display("FAIL ovf_stuck got=%b/%b exp=0/1",
               in_ready, cpu_hold); end
    if (wa_q.size() !== 0) begin bad++;
      $display("FAIL ovf_nwr got=%0d exp=0", wa_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    test_reset();
    clear_mon();
    strm = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66};
    send_all(0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total += 6;
    if (wa_q.size() !== 1) begin bad++;
      $display("FAIL mid_nwr got=%0d exp=1", wa_q.size()); end
    else if (wa_q[0] !== 16'h0 || wd_q[0] !== 32'h44332211) begin
      bad++;
      $display("FAIL mid_w0 got=%h/%h exp=0000/44332211",
               wa_q[0], wd_q[0]);
    end
    if (mem_addr !== '0 || mem_wdata !== '0) begin bad++;
      $display("FAIL mid_rst_bus got=%h/%h exp=0/0",
               mem_addr, mem_wdata); end
    if (in_ready !== 1'b0 || mem_we !== 1'b0) begin bad++;
      $display("FAIL mid_rst_rdy got=%b/%b exp=0/0",
               in_ready, mem_we); end
    if (cpu_hold !== 1'b1) begin bad++;
      $display("FAIL mid_rst_hold got=%b exp=1", cpu_hold); end
    if (done !== 1'b0 || err !== 1'b0) begin bad++;
      $display("FAIL mid_rst_flags got=%b/%b exp=0/0", done, err); end
    @(posedge clk); #1;
    test_reset();
    clear_mon();
    strm = '{8'h01, 8'h00, 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom)};
    build_exp();
    send_all(0, 2);
    wait_done(50);
    total += 2;
    if (tmo !== 1'b0 || done !== 1'b1) begin bad++;
      $display("FAIL mid_fresh_done got=%b/%b exp=0/1", tmo, done); end
    if (wa_q.size() !== 1 || wa_q[0] !== 16'h0 ||
        wd_q[0] !== exp_d[0]) begin
      bad++;
      $display("FAIL mid_fresh_w got=%0d exp=1 data exp=%h",
               wa_q.size(), exp_d[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_bubbles();
    test_zero();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle processor's instruction memory. It receives a length-prefixed little-endian byte stream over a valid/ready interface and assembles 32-bit instruction words. It writes those words into the instruction memory write port starting at byte address 0, and holds the processor (PC and register-file writes) stalled until the image is complete.

## Interface
Parameters:
- INST_MEMORY_ADDR_BUS_WIDTH, 16, byte-address width of the instruction memory; capacity is 2^(INST_MEMORY_ADDR_BUS_WIDTH-2) words.
- INST_MEMORY_DATA_BUS_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  single-cycle request to reload; honoured only in DONE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  INST_MEMORY_ADDR_BUS_WIDTH  byte address of the write; always word-aligned.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  high while the processor must not advance.
- done  out  1  image loaded successfully; sticky.
- err  out  1  image length exceeds capacity; sticky until reset.

## Operation
- States: IDLE, HDR_LO, HDR_HI, DATA, DONE, ERR.
- IDLE: reset state. Moves unconditionally to HDR_LO on the next cycle.
- HDR_LO: accepted byte goes to word_count[7:0].
- HDR_HI: accepted byte goes to word_count[15:8]. Next state is chosen from the full 16-bit count N:
  - N == 0 → DONE, with no writes.
  - N > 2^(INST_MEMORY_ADDR_BUS_WIDTH-2) → ERR.
  - otherwise → DATA.
- DATA byte assembly: bytes are packed little-endian; the first byte of a word goes to bits [7:0] and the fourth to bits [31:24]. A 2-bit byte counter tracks position within the word.
- DATA word write: on acceptance of the 4th byte, the next cycle drives:
  - mem_we = 1
  - mem_wdata = the full word
  - mem_addr = word_idx × 4
  - word_idx then increments.
- DATA exit: once the write of word N-1 is issued, the state moves to DONE.
- DONE: done = 1 and cpu_hold = 0. A start pulse clears done, asserts cpu_hold and moves to HDR_LO; the next image overwrites from address 0.
- ERR: in_ready = 0, cpu_hold = 1, err = 1; no further writes. Exit is by reset only.
- in_ready = 1 only in HDR_LO, HDR_HI and DATA.
- in_data is ignored whenever in_valid is 0. Bubbles (in_valid low) may occur anywhere in the stream and only stretch the load.
- mem_addr arithmetic: word_idx is INST_MEMORY_ADDR_BUS_WIDTH-2 bits wide, and mem_addr = {word_idx, 2'b00}. The capacity check guarantees word_idx never wraps during a legal load.
- Between write pulses mem_addr and mem_wdata hold their last values, and mem_we = 0.

## Timing
- Reset values while rst_n = 0 (outputs registered or decoded from registered state):
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - cpu_hold = 1, done = 0, err = 0
  - state = IDLE
- First in_ready = 1 occurs 1 cycle after rst_n rises, because of the IDLE→HDR_LO transition.
- Write latency: mem_we is asserted exactly 1 cycle after the handshake of a word's 4th byte.
- Streaming throughput: one byte per cycle; in_ready stays high through DATA, including the write cycle.
- cpu_hold falls, and done rises, in the cycle after the final mem_we pulse. For N == 0 this happens in the cycle after the HDR_HI handshake.
- err rises, and in_ready falls, in the cycle after the HDR_HI handshake when N exceeds capacity.
- start in any state other than DONE has no effect.
- Reset mid-load:
  - Returns to IDLE within one edge and kills any pending mem_we.
  - Partial words are discarded.
  - Already-written words remain in memory; the next load overwrites them.

## Test plan
- Reset then stream 02 00 13 05 a0 00 93 05 b0 00 -> mem_we pulses twice: addr 0x0000 data 0x00A00513, then addr 0x0004 data 0x00B00593. After that cpu_hold = 0 and done = 1.
- Same image with in_valid low for 3 cycles between every byte -> identical writes and data. Each mem_we comes 1 cycle after the 4th byte handshake, and no extra pulses occur.
- Header 00 00 -> no mem_we. done = 1 and cpu_hold = 0 in the cycle after the second header byte.
- Header 01 40 (N = 16385, capacity 16384) -> err = 1, in_ready = 0, cpu_hold = 1, no writes. A following start pulse has no effect.
- Reset asserted after 6 data bytes of a 2-word image -> exactly one mem_we (addr 0) is seen. After reset, outputs hold their reset values and in_ready returns 1 cycle after rst_n rises. A fresh 1-word load then writes addr 0.
- After DONE, a start pulse plus the image 01 00 ef be ad de -> cpu_hold rises the next cycle. mem_we fires with addr 0x0000 data 0xDEADBEEF, then done = 1.
